// File: rtl/reset_sequencer_pkg.sv
// Shared types for the staged reset sequencer: FSM states, reset-cause
// encoding and a small sizing helper.
package reset_sequencer_pkg;

   localparam int unsigned CAUSE_W = 2;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_e;

   typedef enum logic [CAUSE_W-1:0] {
      POR   = 2'd0,
      SOFT  = 2'd1,
      FIELD = 2'd2
   } cause_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage : reset_sequencer_pkg

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: hold all outputs low, then release them
// one stage at a time in increasing index order. Optional RESET_SEQUENCER_CAUSE_EN
// adds a last_cause output recording why the most recent re-sequence happened.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned STAGE_GAP   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  soft_rst_req,
   input  logic                  field_ok,
   output logic [NUM_STAGES-1:0] rst_n_out,
   output logic                  busy
`ifdef RESET_SEQUENCER_CAUSE_EN
   ,
   output cause_e                last_cause
`endif
);

   localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
   localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
   localparam logic [NUM_STAGES-1:0] ALL_REL = '1;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   out_q, out_d;
   logic                    busy_q, busy_d;
   logic                    trig_c;

   // Any request or missing field forces a full restart of the sequence
   assign trig_c = soft_rst_req | ~field_ok;

   // State, counter, stage index and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      out_d   = out_q;

      if (trig_c) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         out_d   = '0;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  out_d   = out_q | NUM_STAGES'(1);
                  cnt_d   = '0;
                  idx_d   = IDX_W'(1);
                  state_d = (NUM_STAGES == 1) ? RUN : RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                  out_d = out_q | (NUM_STAGES'(1) << idx_q);
                  cnt_d = '0;
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                     state_d = RUN;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               cnt_d = '0;
               out_d = ALL_REL;
            end
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               out_d   = '0;
            end
         endcase
      end

      // busy tracks the next output value so both change on the same edge
      busy_d = (out_d != ALL_REL);
   end

   assign rst_n_out = out_q;
   assign busy      = busy_q;

`ifdef RESET_SEQUENCER_CAUSE_EN
   cause_e cause_q, cause_d;

   // Field loss outranks a soft request when both arrive together
   always_comb begin
      cause_d = cause_q;
      if (!field_ok) begin
         cause_d = FIELD;
      end else if (soft_rst_req) begin
         cause_d = SOFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_q <= POR;
      end else begin
         cause_q <= cause_d;
      end
   end

   assign last_cause = cause_q;
`endif

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default-parameter instance plus a
// 3-stage / 1-cycle instance; expectations queued by stimulus, popped by a monitor.
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       soft_rst_req;
   logic       field_ok;
   logic [1:0] out_a;
   logic       busy_a;
   logic [2:0] out_b;
   logic       busy_b;
`ifdef RESET_SEQUENCER_CAUSE_EN
   cause_e     cause_a;
   cause_e     cause_b;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      nm;
      bit         sel;
      logic [2:0] o;
      logic       b;
      logic [1:0] c;
   } exp_t;

   exp_t q[$];

   reset_sequencer #(.NUM_STAGES(2), .HOLD_CYCLES(4), .STAGE_GAP(2)) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst_req (soft_rst_req),
      .field_ok     (field_ok),
      .rst_n_out    (out_a),
      .busy         (busy_a)
`ifdef RESET_SEQUENCER_CAUSE_EN
      ,
      .last_cause   (cause_a)
`endif
   );

   reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .soft_rst_req (soft_rst_req),
      .field_ok     (field_ok),
      .rst_n_out    (out_b),
      .busy         (busy_b)
`ifdef RESET_SEQUENCER_CAUSE_EN
      ,
      .last_cause   (cause_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input bit sel, input logic [2:0] eo,
                      input logic eb, input logic [1:0] ec);
      logic [2:0] go;
      logic       gb;
      logic [1:0] gc;
      go = sel ? out_b : {1'b0, out_a};
      gb = sel ? busy_b : busy_a;
      gc = ec;
`ifdef RESET_SEQUENCER_CAUSE_EN
      gc = sel ? 2'(cause_b) : 2'(cause_a);
`endif
      checks++;
      if (go !== eo || gb !== eb || gc !== ec) begin
         errors++;
         $display("FAIL %s: got out=%b busy=%b cause=%0d, want out=%b busy=%b cause=%0d",
                  nm, go, gb, gc, eo, eb, ec);
      end
   endtask

   // Monitor: one expectation per rising edge, sampled just after it
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, e.sel, e.o, e.b, e.c);
         end
      end
   end

   // Release order: outputs must always form a low-index-first thermometer
   initial begin
      forever begin
         @(negedge clk);
         begin
            logic [2:0] ta;
            logic [2:0] tb;
            ta = {1'b0, out_a};
            tb = out_b;
            checks++;
            if ((((ta + 3'd1) & ta) != 3'd0) || (((tb + 3'd1) & tb) != 3'd0)) begin
               errors++;
               $display("FAIL release_order: got a=%b b=%b, want thermometer codes", out_a, out_b);
            end
         end
      end
   end

   task automatic step(input string nm, input logic s, input logic f, input logic [2:0] o,
                       input logic b, input logic [1:0] c, input bit sel);
      exp_t e;
      @(negedge clk);
      soft_rst_req = s;
      field_ok     = f;
      e.nm  = nm;
      e.sel = sel;
      e.o   = o;
      e.b   = b;
      e.c   = c;
      q.push_back(e);
      @(posedge clk);
   endtask

   // Full default sequence with no request: 3 edges low, stage 0 on 4th, stage 1 on 6th
   task automatic run_seq(input string nm, input logic [1:0] c);
      for (int i = 0; i < 3; i++) step(nm, 1'b0, 1'b1, 3'b000, 1'b1, c, 1'b0);
      step({nm, "_s0"}, 1'b0, 1'b1, 3'b001, 1'b1, c, 1'b0);
      step({nm, "_gap"}, 1'b0, 1'b1, 3'b001, 1'b1, c, 1'b0);
      step({nm, "_s1"}, 1'b0, 1'b1, 3'b011, 1'b0, c, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      soft_rst_req = 1'b0;
      field_ok     = 1'b1;
      #12;
      chk("por_a", 1'b0, 3'b000, 1'b1, 2'(POR));
      chk("por_b", 1'b1, 3'b000, 1'b1, 2'(POR));
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_seq("por_seq", 2'(POR));
      step("run_idle", 1'b0, 1'b1, 3'b011, 1'b0, 2'(POR), 1'b0);

      step("soft_pulse", 1'b1, 1'b1, 3'b000, 1'b1, 2'(SOFT), 1'b0);
      run_seq("soft_seq", 2'(SOFT));

      // Reach mid-RELEASE (stage 0 out), then drop the field for 10 edges
      step("soft_pulse2", 1'b1, 1'b1, 3'b000, 1'b1, 2'(SOFT), 1'b0);
      for (int i = 0; i < 3; i++) step("hold2", 1'b0, 1'b1, 3'b000, 1'b1, 2'(SOFT), 1'b0);
      step("rel0_mid", 1'b0, 1'b1, 3'b001, 1'b1, 2'(SOFT), 1'b0);
      for (int i = 0; i < 10; i++) step("field_low", 1'b0, 1'b0, 3'b000, 1'b1, 2'(FIELD), 1'b0);
      run_seq("field_seq", 2'(FIELD));

      // Asynchronous reset while running: outputs drop with no clock edge
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_run", 1'b0, 3'b000, 1'b1, 2'(POR));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Asynchronous reset mid-HOLD restarts the hold count
      for (int i = 0; i < 2; i++) step("hold_pre", 1'b0, 1'b1, 3'b000, 1'b1, 2'(POR), 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_hold", 1'b0, 3'b000, 1'b1, 2'(POR));
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_seq("restart_seq", 2'(POR));

      step("both_trig", 1'b1, 1'b0, 3'b000, 1'b1, 2'(FIELD), 1'b0);
      run_seq("both_seq", 2'(FIELD));

      // Three-stage instance with single-cycle hold and gap
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("b_reset", 1'b1, 3'b000, 1'b1, 2'(POR));
      @(posedge clk);
      #1 rst_n = 1'b1;
      step("b_edge1", 1'b0, 1'b1, 3'b001, 1'b1, 2'(POR), 1'b1);
      step("b_edge2", 1'b0, 1'b1, 3'b011, 1'b1, 2'(POR), 1'b1);
      step("b_edge3", 1'b0, 1'b1, 3'b111, 1'b0, 2'(POR), 1'b1);
      step("b_run",   1'b0, 1'b1, 3'b111, 1'b0, 2'(POR), 1'b1);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reset_sequencer

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Generates the staged, active-low reset outputs for the tag core's clock domain.
- Holds all outputs asserted for a minimum time after power-on reset, a soft-reset request or loss of the RF field.
- Then releases the outputs one stage at a time, lowest index first (stage 0 = analogue/front-end logic, higher stages = protocol and application logic).
- Each output is a registered, glitch-free active-low reset suitable for feeding per-domain reset synchronisers.

Parameters:
NUM_STAGES, 2, number of sequenced reset outputs (>=1)
HOLD_CYCLES, 4, rising clk edges all outputs stay low before stage 0 releases (>=1)
STAGE_GAP, 2, rising clk edges between release of stage k-1 and stage k (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
soft_rst_req  input  1  synchronous pulse or level; requests a full re-sequence
field_ok  input  1  synchronous level; low = RF field absent, hold everything in reset
rst_n_out  output  NUM_STAGES  sequenced active-low resets, bit k = stage k
busy  output  1  high while any rst_n_out bit is low

Behaviour:
- Only one clock; reset is asynchronous and active-low.
- On rst_n low (asynchronous, immediate):
  - rst_n_out = all 0, busy = 1, state = HOLD, counter = 0, stage index = 0.
  - All outputs, state, counter and stage index are flops reset by rst_n.
- States: HOLD, RELEASE, RUN.
- HOLD:
  - Counter increments each edge while field_ok=1 and soft_rst_req=0.
  - On the edge where counter == HOLD_CYCLES-1: rst_n_out[0] <= 1, counter <= 0, stage index <= 1.
  - Next state is RELEASE, or RUN if NUM_STAGES == 1.
  - Net effect: stage 0 rises on the HOLD_CYCLES-th edge after entering HOLD with no request active.
- RELEASE:
  - Counter increments each edge.
  - On the edge where counter == STAGE_GAP-1: rst_n_out[idx] <= 1, counter <= 0, idx++.
  - Enter RUN on the edge that releases stage NUM_STAGES-1.
- RUN: rst_n_out all 1, busy = 0, counter idle at 0.
- busy is registered: it is 0 exactly when rst_n_out is all 1s, with zero relative lag.
- Release order is strictly increasing index; no bit ever rises before a lower-indexed bit.
- Re-sequence trigger (soft_rst_req=1 or field_ok=0), sampled on an edge in any state:
  - Next edge: rst_n_out <= all 0, busy <= 1, state <= HOLD, counter <= 0, idx <= 0.
  - Applies mid-HOLD (counter restarts) and mid-RELEASE (already-released stages re-assert).
- A level trigger (field_ok held low, or soft_rst_req held high) keeps the block in HOLD with counter 0 until it clears.
- soft_rst_req and field_ok low on the same edge: identical to either alone.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP)+1). It must never wrap.
- soft_rst_req and field_ok are assumed already synchronous to clk; no internal synchronisation.

Optional Feature:
RESET_SEQUENCER_CAUSE_EN
- Defined: adds output last_cause (2 bits, package enum).
  - Encodings: POR=0, SOFT=1, FIELD=2.
  - Reset value POR.
  - Updated on the edge a re-sequence trigger is accepted: FIELD takes priority over SOFT.
  - Holds its value through RUN.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package reset_sequencer_pkg:
  - state enum {HOLD, RELEASE, RUN}
  - cause enum {POR, SOFT, FIELD}
  - cause width constant
- No sub-module: a single counter plus stage index plus FSM. A separate counter module adds nothing.

Test Plan:
- Defaults (NUM_STAGES=2, HOLD_CYCLES=4, STAGE_GAP=2), rst_n released, field_ok=1 -> rst_n_out 00 for edges 1-3; 01 after edge 4; 11 after edge 6; busy falls after edge 6.
- In RUN, 1-cycle soft_rst_req -> rst_n_out=00, busy=1 after next edge; full 4+2 sequence repeats; last_cause=SOFT if enabled.
- field_ok low 10 cycles mid-RELEASE (rst_n_out=01) -> 00 next edge, stays 00 for all 10; stage 0 rises 4 edges after field_ok returns high; last_cause=FIELD.
- rst_n asserted mid-HOLD between clock edges -> rst_n_out=00 immediately (no edge needed); sequence restarts from count 0 on release.
- NUM_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1 -> 001, 011, 111 on edges 1, 2, 3; release order never violated (assertion).
- soft_rst_req and field_ok=0 on the same edge in RUN -> single re-sequence; last_cause=FIELD.
